seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// It shares one external SevenSegment decoder between all digits: drives dec_bcd and
// registers dec_seg onto seg, while cycling the digit enables in an.
// It buffers one pending display word with a valid/ready handshake and applies it only
// at a frame boundary, so a displayed frame never mixes old and new digit values.
// PARAMETERS
// NUM_DIGITS   4         digits scanned; digit 0 = load_data[3:0] (rightmost)
// REFRESH_DIV  50000     clk cycles each digit is lit (ON phase), >=1
// DEAD_CYCLES  2         cycles all anodes are off before each digit (anti-ghosting), >=1
// BLANK_SEG    7'h7F     seg value for a dark digit (active-low segments)
// PORTS
// clk           in   1              system clock, rising edge
// rst_n         in   1              asynchronous active-low reset
// en            in   1              1 = scan display, 0 = display dark
// blank_lz      in   1              1 = suppress leading zeros
// load_valid    in   1              load_data is valid
// load_ready    out  1              pending buffer empty, load can be accepted
// load_data     in   4*NUM_DIGITS   BCD digits, 4 bits per digit
// dec_bcd       out  4              BCD value to the shared SevenSegment decoder
// dec_seg       in   7              decoder output (combinational from dec_bcd)
// seg           out  7              registered segment drive
// an            out  NUM_DIGITS     digit enables, active-low one-hot; all 1 = all off
// frame_done    out  1              1-cycle pulse when the last digit finishes
// BEHAVIOUR
// - Reset: state OFF; idx=0; prescaler=0; display reg=0; pending empty; load_ready=1;
//   an=all 1; seg=BLANK_SEG; frame_done=0; dec_bcd=0.
// - FSM states:
//   - OFF -> DEAD when en=1.
//   - DEAD -> ON after DEAD_CYCLES cycles.
//   - ON -> DEAD after REFRESH_DIV cycles, and idx increments. When idx=NUM_DIGITS-1 it
//     wraps to 0 instead (the wrap cycle).
//   - Any state -> OFF on the cycle after en=0; this clears idx and the prescaler.
// - Digit period = DEAD_CYCLES + REFRESH_DIV cycles; frame = NUM_DIGITS * digit period.
// - dec_bcd = display[idx] at all times. Values 10..15 pass to the decoder unmodified.
// - Outputs are registered and lag the FSM state by one cycle.
//   - OFF/DEAD: an=all 1, seg=BLANK_SEG.
//   - ON: an[idx]=0 (others 1). seg=dec_seg, or BLANK_SEG if the digit is blanked.
// - Leading-zero blank: digit i is blanked when blank_lz=1, i>0, and digits i..N-1 are
//   all 0. Digit 0 is never blanked.
// - Handshake:
//   - A load is accepted when load_valid && load_ready; load_data goes into the pending
//     buffer and load_ready drops on the next cycle.
//   - The pending buffer copies to the display reg in the wrap cycle, which also pulses
//     frame_done. load_ready returns to 1 on the next cycle.
//   - A load accepted in the wrap cycle itself stays pending until the next wrap.
//   - In OFF, a pending buffer copies to the display reg on the next cycle.
//   - load_data is ignored when load_ready=0. load_valid is held by the sender.
// - en=0 mid-scan keeps the display reg and pending buffer. Re-enabling restarts at
//   digit 0 with a DEAD phase.
// - An asynchronous reset mid-operation discards the pending buffer; outputs go dark.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1)
// 1. Assert rst_n=0 with en=1 -> an=4'b1111, seg=7'h7F, load_ready=1, frame_done=0.
// 2. Load 16'h1234 while en=0, then set en=1.
//    -> dec_bcd during ON phases: 4,3,2,1.
//    -> an: 1110,1101,1011,0111, each low 4 cycles with 1 all-off cycle between.
//    -> frame_done pulses every 20 cycles.
// 3. Showing 1234, load 16'h5678 while digit 1 is lit.
//    -> digits 2,3 of this frame still show 2,1; load_ready=0 until the frame ends.
//    -> next frame shows 8,7,6,5.
// 4. blank_lz=1, load 16'h0070 -> digits 3,2 show seg=7'h7F; digit 1 shows the decoded
//    7; digit 0 shows the decoded 0.
//    16'h0000 -> only digit 0 is lit, showing the decoded 0.
// 5. Drop en while digit 2 is lit -> an=4'b1111 within 2 cycles; pending data is
//    retained.
//    Raise en again -> 1 dead cycle, then an=4'b1110.
// 6. Pulse rst_n low mid-frame with a load pending -> immediately an=4'b1111, seg=7'h7F,
//    load_ready=1; after release, the display reg is 0.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// Display-side bus of the seven-segment scan controller: load handshake, shared decoder
// hookup and the segment/anode drive.
interface seven_seg_scan_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      en;
   logic                      blank_lz;
   logic                      load_valid;
   logic                      load_ready;
   logic [4*NUM_DIGITS-1:0]   load_data;
   logic [3:0]                dec_bcd;
   logic [6:0]                dec_seg;
   logic [6:0]                seg;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_done;

   // Master is the host plus the external decoder; slave is the scan controller.
   modport master (
      output en, blank_lz, load_valid, load_data, dec_seg,
      input  load_ready, dec_bcd, seg, an, frame_done
   );

   modport slave (
      input  en, blank_lz, load_valid, load_data, dec_seg,
      output load_ready, dec_bcd, seg, an, frame_done
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display,
// with a one-word pending buffer that is applied only at frame boundaries.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD_CYCLES = 2,
   parameter logic [6:0]  BLANK_SEG   = 7'h7F
) (
   input logic             clk,
   input logic             rst_n,
   seven_seg_scan_if.slave bus
);

   localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CntMax = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned DataW  = 4 * NUM_DIGITS;

   localparam logic [IdxW-1:0] LastIdx     = IdxW'(NUM_DIGITS - 1);
   localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] DeadLast    = CntW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {StOff, StDead, StOn} state_e;

   state_e                  state_q;
   logic [IdxW-1:0]         idx_q;
   logic [CntW-1:0]         cnt_q;
   logic [DataW-1:0]        disp_q;
   logic [DataW-1:0]        pend_q;
   logic                    pend_vld_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [6:0]              seg_q;
   logic                    fd_q;

   logic [3:0]              cur_digit;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   an_on;
   logic                    zero_run;
   logic                    accept;
   logic                    wrap;

   // Walk from the top digit down so zero_run tracks "this digit and all above are 0".
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      an_on     = '1;
      zero_run  = bus.blank_lz;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
         if (idx_q == IdxW'(i)) begin
            cur_digit = disp_q[4*i +: 4];
            cur_blank = zero_run && (i > 0);
            an_on[i]  = 1'b0;
         end
      end
   end

   assign accept = bus.load_valid && !pend_vld_q;
   assign wrap   = bus.en && (state_q == StOn) && (cnt_q == RefreshLast) && (idx_q == LastIdx);

   assign bus.load_ready = ~pend_vld_q;
   assign bus.dec_bcd    = cur_digit;
   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_done = fd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StOff;
         idx_q      <= '0;
         cnt_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         an_q       <= '1;
         seg_q      <= BLANK_SEG;
         fd_q       <= 1'b0;
      end else begin
         // Drive registers reflect the state being left, hence the one-cycle lag.
         an_q  <= (state_q == StOn) ? an_on : '1;
         seg_q <= ((state_q == StOn) && !cur_blank) ? bus.dec_seg : BLANK_SEG;
         fd_q  <= wrap;

         // Accept and apply are exclusive: accept needs an empty buffer, apply a full one.
         if (accept) begin
            pend_q     <= bus.load_data;
            pend_vld_q <= 1'b1;
         end else if (pend_vld_q && (wrap || (state_q == StOff))) begin
            disp_q     <= pend_q;
            pend_vld_q <= 1'b0;
         end

         if (!bus.en) begin
            state_q <= StOff;
            idx_q   <= '0;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               StOff: begin
                  state_q <= StDead;
                  cnt_q   <= '0;
               end
               StDead: begin
                  if (cnt_q == DeadLast) begin
                     state_q <= StOn;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StOn: begin
                  if (cnt_q == RefreshLast) begin
                     state_q <= StDead;
                     cnt_q   <= '0;
                     idx_q   <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: state_q <= StOff;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues the expected {an, seg} of every
// lit cycle, a negedge monitor pops and compares whenever a digit is driven.
module tb_seven_seg_scan_ctrl;

   localparam int unsigned ND = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(4),
      .DEAD_CYCLES(1),
      .BLANK_SEG  (7'h7F)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Active-low gfedcba hex decoder standing in for the external SevenSegment part.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;  4'h2: seg_of = 7'h24;
         4'h3: seg_of = 7'h30;  4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
         4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;  4'h8: seg_of = 7'h00;
         4'h9: seg_of = 7'h10;  4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
         4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;  4'hE: seg_of = 7'h06;
         default: seg_of = 7'h0E;
      endcase
   endfunction

   assign bus.dec_seg = seg_of(bus.dec_bcd);

   int          vectors     = 0;
   int          miscompares = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_e;
   bit          mon_on      = 1'b1;
   int          cyc         = 0;
   int          last_fd     = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_digit(input logic [15:0] v, input int i, input bit blz, input int n);
      logic [3:0] an_e;
      logic [6:0] s;
      an_e    = 4'hF;
      an_e[i] = 1'b0;
      s = (blz && (i > 0) && ((v >> (4 * i)) == 16'd0)) ? 7'h7F : seg_of(v[4*i +: 4]);
      repeat (n) exp_q.push_back({an_e, s});
   endtask

   task automatic push_frame(input logic [15:0] v, input bit blz);
      for (int i = 0; i < 4; i++) push_digit(v, i, blz, 4);
   endtask

   task automatic load_word(input logic [15:0] v);
      bus.load_data  = v;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic wait_an(input logic [3:0] target, input int budget);
      int n;
      n = 0;
      while (bus.an !== target && n < budget) begin
         tick();
         n++;
      end
      if (bus.an !== target) check("wait_an_timeout", bus.an, target);
   endtask

   task automatic wait_fd(input int budget);
      int n;
      n = 0;
      tick();
      while (bus.frame_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (bus.frame_done !== 1'b1) check("wait_fd_timeout", bus.frame_done, 1);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic show_frames(input int budget);
      bus.en = 1'b1;
      wait_drain(budget);
      bus.en = 1'b0;
      tick();
      tick();
   endtask

   // Monitor: every lit cycle must match the next queued expectation.
   always @(negedge clk) begin
      cyc++;
      if (mon_on && rst_n && bus.an !== 4'hF) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_lit: got an=%b seg=%h, expected no lit digit", bus.an,
                     bus.seg);
         end else begin
            mon_e = exp_q.pop_front();
            check("lit_digit", {bus.an, bus.seg}, mon_e);
         end
      end
      if (!rst_n || !bus.en) begin
         last_fd = -1;
      end else if (bus.frame_done) begin
         if (last_fd >= 0) check("frame_period", cyc - last_fd, 20);
         last_fd = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ready_hi;
      bus.en         = 1'b1;
      bus.blank_lz   = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;

      // 1: reset state with en asserted
      #12;
      check("rst_an", bus.an, 4'hF);
      check("rst_seg", bus.seg, 7'h7F);
      check("rst_ready", bus.load_ready, 1);
      check("rst_fd", bus.frame_done, 0);
      check("rst_bcd", bus.dec_bcd, 0);
      bus.en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // 2: load while off, then scan two frames
      load_word(16'h1234);
      tick();
      tick();
      check("off_copy_ready", bus.load_ready, 1);
      check("off_copy_bcd", bus.dec_bcd, 4);
      push_frame(16'h1234, 1'b0);
      push_frame(16'h1234, 1'b0);
      show_frames(120);

      // 3: load mid-frame, applied only at the wrap
      push_frame(16'h1234, 1'b0);
      push_frame(16'h1234, 1'b0);
      push_frame(16'h5678, 1'b0);
      bus.en = 1'b1;
      wait_fd(60);
      wait_an(4'b1101, 20);
      load_word(16'h5678);
      check("ready_drop", bus.load_ready, 0);
      n = 0;
      ready_hi = 0;
      while (bus.frame_done !== 1'b1 && n < 40) begin
         if (bus.load_ready) ready_hi++;
         tick();
         n++;
      end
      check("ready_low_until_wrap", ready_hi, 0);
      check("wrap_seen", bus.frame_done, 1);
      check("ready_after_wrap", bus.load_ready, 1);
      wait_drain(60);
      bus.en = 1'b0;
      tick();
      tick();

      // 4: leading-zero blanking
      bus.blank_lz = 1'b1;
      load_word(16'h0070);
      tick();
      tick();
      check("lz_bcd", bus.dec_bcd, 0);
      push_frame(16'h0070, 1'b1);
      show_frames(60);
      load_word(16'h0000);
      tick();
      tick();
      push_frame(16'h0000, 1'b1);
      show_frames(60);
      bus.blank_lz = 1'b0;

      // Codes 10..15 pass straight to the decoder
      load_word(16'hABCD);
      tick();
      tick();
      check("hex_bcd", bus.dec_bcd, 4'hD);
      push_frame(16'hABCD, 1'b0);
      show_frames(60);

      // 5: drop en mid-frame with a load pending, then re-enable
      load_word(16'h4321);
      tick();
      tick();
      check("pre5_bcd", bus.dec_bcd, 1);
      push_digit(16'h4321, 0, 1'b0, 4);
      push_digit(16'h4321, 1, 1'b0, 4);
      push_digit(16'h4321, 2, 1'b0, 2);
      bus.en = 1'b1;
      wait_an(4'b1101, 30);
      load_word(16'h8765);
      check("pend_held", bus.load_ready, 0);
      wait_an(4'b1011, 20);
      bus.en = 1'b0;
      n = 0;
      while (bus.an !== 4'hF && n < 8) begin
         tick();
         n++;
      end
      check("dark_after_en_drop", n, 2);
      tick();
      tick();
      check("pend_applied_off", bus.load_ready, 1);
      check("pend_applied_bcd", bus.dec_bcd, 5);
      push_frame(16'h8765, 1'b0);
      bus.en = 1'b1;
      n = 0;
      tick();
      while (bus.an === 4'hF && n < 8) begin
         n++;
         tick();
      end
      check("redead_cycles", n, 2);
      check("redead_digit0", bus.an, 4'b1110);
      wait_drain(60);
      bus.en = 1'b0;
      tick();
      tick();

      // 6: asynchronous reset mid-frame with a load pending
      mon_on = 1'b0;
      bus.en = 1'b1;
      wait_an(4'b1101, 30);
      load_word(16'h1111);
      check("pend6_held", bus.load_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_an", bus.an, 4'hF);
      check("arst_seg", bus.seg, 7'h7F);
      check("arst_ready", bus.load_ready, 1);
      check("arst_fd", bus.frame_done, 0);
      bus.en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("arst_disp_bcd", bus.dec_bcd, 0);
      check("arst_ready_after", bus.load_ready, 1);
      mon_on = 1'b1;
      push_frame(16'h0000, 1'b0);
      show_frames(60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
